// File: rtl/mem_pkg.sv
// Shared types and constants for the IF/MEM memory arbiter.
package mem_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam int unsigned MEM_BYTES_DEFAULT = 1024;

  // Word accesses must be 4-byte aligned and land entirely inside the memory.
  function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] last_word);
    return (addr[1:0] != 2'b00) || (addr > last_word);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Data-first priority pick with a starvation counter that hands the
// contested arbitration to the instruction port after STARVE_LIMIT data wins.
module mem_arb_prio
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  input  logic gnt_en,
  output logic sel_i,
  output logic sel_d
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == LIMIT);
  assign sel_d   = gnt_en && d_req && !(i_req && starved);
  assign sel_i   = gnt_en && i_req && !sel_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!i_req || sel_i) begin
      starve_cnt <= '0;
    end else if (sel_d && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-ported byte memory;
// each access is IDLE (grant) -> ACCESS (strobe) -> registered response.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = MEM_BYTES_DEFAULT,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_t      state;
  port_t       lat_port;
  logic        lat_we;
  logic        lat_err;
  logic        sel_i;
  logic        sel_d;
  logic        gnt_en;
  logic        req_we;
  logic [31:0] req_addr;
  logic        req_err;
  logic [31:0] rsp_data;

  // Grants are gated by rst_n so nothing is offered while reset is held.
  assign gnt_en = rst_n && (state == ST_IDLE);

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (i_req),
    .d_req (d_req),
    .gnt_en(gnt_en),
    .sel_i (sel_i),
    .sel_d (sel_d)
  );

  assign i_gnt    = sel_i;
  assign d_gnt    = sel_d;
  assign req_we   = sel_d && d_we;
  assign req_addr = sel_d ? d_addr : i_addr;
  assign req_err  = addr_bad(req_addr, LAST_WORD);
  assign rsp_data = (!lat_we && !lat_err) ? mem_rd : '0;

  // Memory strobes are registered at the grant edge, so an async reset during
  // ACCESS clears mem_write immediately and the write is never committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lat_port  <= PORT_I;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
      i_rvalid  <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_i || sel_d) begin
            state     <= ST_ACCESS;
            lat_port  <= sel_d ? PORT_D : PORT_I;
            lat_we    <= req_we;
            lat_err   <= req_err;
            mem_addr  <= req_addr;
            mem_read  <= !req_we && !req_err;
            mem_write <= req_we && !req_err;
            mem_wd    <= (req_we && !req_err) ? d_wdata : '0;
          end
        end
        ST_ACCESS: begin
          state     <= ST_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          mem_addr  <= '0;
          mem_wd    <= '0;
          if (lat_port == PORT_D) begin
            d_rvalid <= 1'b1;
            d_rdata  <= rsp_data;
            d_err    <= lat_err;
          end else begin
            i_rvalid <= 1'b1;
            i_rdata  <= rsp_data;
            i_err    <= lat_err;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
